// File: rtl/exp_one_if.sv
// Flag/decision bundle for exp_one: upstream drives flags and strobes, the block returns
// the registered decision and the hit counter.
interface exp_one_if #(
    parameter int CNT_W = 8
);
    logic             r;
    logic             c;
    logic             p;
    logic             g;
    logic             in_valid;
    logic             cnt_clr;
    logic             out;
    logic             out_valid;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output r, c, p, g, in_valid, cnt_clr,
        input  out, out_valid, hit_count
    );

    modport slave (
        input  r, c, p, g, in_valid, cnt_clr,
        output out, out_valid, hit_count
    );
endinterface

// File: rtl/exp_one.sv
// Registered four-flag decision with an optional saturating hit counter.
// Define EXP_ONE_HIT_CNT_EN to build the counter; otherwise hit_count reads 0 and cnt_clr is ignored.
module exp_one #(
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    exp_one_if.slave bus
);
    logic decision;
    logic out_reg;
    logic valid_reg;

    // C and G together always win; R alone needs one of them and no inhibit.
    assign decision = (bus.c & bus.g) | (bus.r & ~bus.p & (bus.c | bus.g));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                out_reg <= decision;
            end
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = valid_reg;

`ifdef EXP_ONE_HIT_CNT_EN
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (bus.cnt_clr) begin
            count_next = '0;
        end else if (bus.in_valid && decision && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bus.hit_count = count_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.hit_count  = '0;
`endif
endmodule

// File: tb/tb_exp_one.sv
// Randomized and directed checks of exp_one against a truth-table reference model.
module tb_exp_one;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EXP_ONE_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    exp_one_if #(.CNT_W(CNT_W)) bus ();

    exp_one #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minterms {r,c,g,p} = 6,7,10,12,14,15
    logic [15:0] truth_mask;
    int          exp_out;
    int          exp_vld;
    int          exp_cnt;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, int'(bus.out), exp_out);
        check({tag, ".out_valid"}, int'(bus.out_valid), exp_vld);
        check({tag, ".hit_count"}, int'(bus.hit_count), CNT_EN ? exp_cnt : 0);
    endtask

    // One clocked transaction: drive at negedge, update model at posedge, check just after.
    task automatic apply(input string tag, input logic [3:0] idx, input logic vld, input logic clr);
        int hit;
        @(negedge clk);
        bus.r        = idx[3];
        bus.c        = idx[2];
        bus.g        = idx[1];
        bus.p        = idx[0];
        bus.in_valid = vld;
        bus.cnt_clr  = clr;
        @(posedge clk);
        hit = int'(truth_mask[idx]);
        if (clr) exp_cnt = 0;
        else if (vld && hit == 1 && exp_cnt < CNT_MAX) exp_cnt++;
        if (vld) exp_out = hit;
        exp_vld = int'(vld);
        #1;
        $display("[TB] %s idx=%0d vld=%0d clr=%0d -> out=%0d out_valid=%0d hit_count=%0d",
                 tag, idx, vld, clr, bus.out, bus.out_valid, bus.hit_count);
        check_all(tag);
    endtask

    initial begin
        truth_mask = 16'hD4C0;
        n_tests = 0;
        n_fail  = 0;
        exp_out = 0;
        exp_vld = 0;
        exp_cnt = 0;
        rst_n        = 1'b0;
        bus.r        = 1'b0;
        bus.c        = 1'b0;
        bus.g        = 1'b0;
        bus.p        = 1'b0;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply("sweep", 4'(i), 1'b1, 1'b0);

        apply("hold_arm", 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) apply("hold", 4'(i), 1'b0, 1'b0);

        apply("clr0", 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) apply("sat", 4'd15, 1'b1, 1'b0);
        apply("clr_win", 4'd15, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) apply("nohit", (i % 2 == 0) ? 4'd11 : 4'd13, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] idx;
            logic       vld;
            logic       clr;
            idx = 4'($urandom_range(0, 15));
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            apply("rand", idx, vld, clr);
        end

        // Mid-stream reset with out=1 and a non-zero count
        apply("pre_rst_clr", 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) apply("pre_rst", 4'd15, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_out = 0;
        exp_vld = 0;
        exp_cnt = 0;
        #1;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        apply("post_rst", 4'd12, 1'b1, 1'b0);
        apply("post_rst_idle", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
